// File: rtl/m68k_eclock_vma_if.sv
// m68k_eclock_vma_if: E clock / VPA-VMA bus signals between the transfer logic and the E/VMA engine
interface m68k_eclock_vma_if;
  logic       E_IN;
  logic       E_OUT;
  logic       E_OE;
  logic       M68K_VPA_n;
  logic       BUS_OWNED;
  logic       CYC_S3;
  logic       CYC_S7;
  logic       VMA_n;
  logic       VMA_OE;
  logic       VPA_DONE;
  logic [3:0] E_PHASE;
  modport master (
    output E_IN, M68K_VPA_n, BUS_OWNED, CYC_S3, CYC_S7,
    input  E_OUT, E_OE, VMA_n, VMA_OE, VPA_DONE, E_PHASE
  );
  modport slave (
    input  E_IN, M68K_VPA_n, BUS_OWNED, CYC_S3, CYC_S7,
    output E_OUT, E_OE, VMA_n, VMA_OE, VPA_DONE, E_PHASE
  );
endinterface

// File: rtl/m68k_eclock_vma.sv
// m68k_eclock_vma: 68000 E clock generator/tracker and VPA/VMA cycle engine; M68K_E_DETECT_EN enables external E detection
module m68k_eclock_vma #(
  parameter int E_LOW     = 6,
  parameter int E_HIGH    = 4,
  parameter int DET_WIN   = 255,
  parameter int DET_EDGES = 3
) (
  input logic                M68K_CLK,
  input logic                M68K_RESET_n,
  m68k_eclock_vma_if.slave   bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WAIT   = 2'd1;
  localparam logic [1:0] ASSERT = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;
  localparam logic [3:0] PMAX   = 4'(E_LOW + E_HIGH - 1);
  localparam logic [3:0] ELOW   = 4'(E_LOW);
  logic       r_e_s1, r_e_s2, r_e_d, r_vpa_s1, r_vpa_s2;
  logic       r_mode, r_eout, r_vma_oe;
  logic [3:0] r_phase;
  logic [1:0] r_state;
  logic       w_fall;
  logic [3:0] w_phase_nxt;
  logic [1:0] w_state_nxt;
  // sync stages reset high so a pulled-up E or idle VPA never looks like an edge
  always_ff @(posedge M68K_CLK) begin
    if (!M68K_RESET_n) begin
      {r_e_s1, r_e_s2, r_e_d}  <= 3'b111;
      {r_vpa_s1, r_vpa_s2}     <= 2'b11;
    end else begin
      {r_e_s1, r_e_s2, r_e_d}  <= {bus.E_IN, r_e_s1, r_e_s2};
      {r_vpa_s1, r_vpa_s2}     <= {bus.M68K_VPA_n, r_vpa_s1};
    end
  end
  // phase resync on external E falls (input mode only) and transfer FSM next state
  always_comb begin
    w_fall      = r_e_d & ~r_e_s2 & ~r_mode;
    w_phase_nxt = w_fall ? 4'd1 : (r_phase == PMAX ? 4'd0 : r_phase + 4'd1);
    w_state_nxt = !bus.BUS_OWNED ? IDLE :
                  r_state == IDLE   ? ((bus.CYC_S3 & ~r_vpa_s2) ? WAIT : IDLE) :
                  r_state == WAIT   ? (!bus.CYC_S3 ? IDLE : (r_phase == 4'd2 ? ASSERT : WAIT)) :
                  r_state == ASSERT ? (r_phase == PMAX ? DONE : ASSERT) :
                  (bus.CYC_S7 ? IDLE : DONE);
  end
`ifdef M68K_E_DETECT_EN
  localparam int WW = $clog2(DET_WIN + 1);
  localparam int EW = $clog2(DET_EDGES + 1);
  localparam logic [WW-1:0] WMAX = WW'(DET_WIN);
  localparam logic [EW-1:0] EMAX = EW'(DET_EDGES);
  logic [WW-1:0] r_win;
  logic [EW-1:0] r_edges;
  // count external E falls inside the window; fall back to driving E if too few arrive
  always_ff @(posedge M68K_CLK) begin
    if (!M68K_RESET_n) begin
      r_win   <= '0;
      r_edges <= '0;
      r_mode  <= 1'b0;
    end else begin
      if (r_win != WMAX) r_win <= r_win + 1'b1;
      if (w_fall && r_win != WMAX && r_edges != EMAX) r_edges <= r_edges + 1'b1;
      if (r_win == WMAX && r_edges != EMAX) r_mode <= 1'b1;
    end
  end
`else
  // no detector: always drive E, starting the first cycle after reset release
  always_ff @(posedge M68K_CLK) begin
    if (!M68K_RESET_n) r_mode <= 1'b0;
    else r_mode <= 1'b1;
  end
`endif
  // E phase counter, E level derived from the next phase so E_OUT lines up with E_PHASE
  always_ff @(posedge M68K_CLK) begin
    if (!M68K_RESET_n) begin
      r_phase  <= 4'd0;
      r_eout   <= 1'b0;
      r_state  <= IDLE;
      r_vma_oe <= 1'b0;
    end else begin
      r_phase  <= w_phase_nxt;
      r_eout   <= w_phase_nxt >= ELOW;
      r_state  <= w_state_nxt;
      r_vma_oe <= bus.BUS_OWNED;
    end
  end
  assign bus.E_OUT    = r_eout;
  assign bus.E_OE     = r_mode;
  assign bus.E_PHASE  = r_phase;
  assign bus.VMA_n    = ~(r_state == ASSERT || r_state == DONE);
  assign bus.VMA_OE   = r_vma_oe;
  assign bus.VPA_DONE = bus.BUS_OWNED & (r_state == ASSERT) & (r_phase == PMAX);
endmodule

// File: tb/tb_m68k_eclock_vma.sv
// tb_m68k_eclock_vma: directed checks of E generation/tracking and the VPA/VMA cycle
module tb_m68k_eclock_vma;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ext_e = 1'b1;
  int   n = 0;
  int   total = 0;
  int   bad = 0;
  m68k_eclock_vma_if bus();
  m68k_eclock_vma dut (.M68K_CLK(clk), .M68K_RESET_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (n=%0d)", tag, got, exp, n);
    end
  endtask
  task automatic tick;
    bus.E_IN = ext_e ? ((n % 10) >= 6) : 1'b1;
    @(posedge clk);
    #1;
    n++;
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    n = 0;
  endtask
  initial begin
    bus.E_IN = 1'b1;
    bus.M68K_VPA_n = 1'b1;
    bus.BUS_OWNED = 1'b1;
    bus.CYC_S3 = 1'b0;
    bus.CYC_S7 = 1'b0;
    do_reset;
    chk("rst_e_out", bus.E_OUT, 0);
    chk("rst_e_oe", bus.E_OE, 0);
    chk("rst_vma_n", bus.VMA_n, 1);
    chk("rst_vma_oe", bus.VMA_OE, 0);
    chk("rst_vpa_done", bus.VPA_DONE, 0);
    chk("rst_phase", bus.E_PHASE, 0);
`ifdef M68K_E_DETECT_EN
    ext_e = 1'b1;
    do_reset;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (n % 10 == 3) chk("resync_phase", bus.E_PHASE, 1);
    end
    while (n < 260) tick;
    chk("ext_e_oe_low", bus.E_OE, 0);
    ext_e = 1'b0;
    do_reset;
    while (n < 255) tick;
    chk("win_e_oe_before", bus.E_OE, 0);
    tick;
    chk("win_e_oe_after", bus.E_OE, 1);
`else
    ext_e = 1'b1;
    do_reset;
    tick;
    chk("nodet_e_oe", bus.E_OE, 1);
    chk("nodet_phase", bus.E_PHASE, 1);
`endif
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("e_phase", bus.E_PHASE, 16'(n % 10));
      chk("e_out", bus.E_OUT, 16'((n % 10) >= 6));
    end
    while (n % 10 != 5) tick;
    bus.CYC_S3 = 1'b1;
    bus.M68K_VPA_n = 1'b0;
    repeat (7) tick;
    chk("vma_wait_p2", bus.VMA_n, 1);
    chk("vma_oe_on", bus.VMA_OE, 1);
    tick;
    chk("vma_assert", bus.VMA_n, 0);
    bus.M68K_VPA_n = 1'b1;
    repeat (5) tick;
    chk("done_p8", bus.VPA_DONE, 0);
    tick;
    chk("done_p9", bus.VPA_DONE, 1);
    chk("done_phase", bus.E_PHASE, 9);
    tick;
    chk("done_once", bus.VPA_DONE, 0);
    chk("vma_held", bus.VMA_n, 0);
    bus.CYC_S3 = 1'b0;
    bus.CYC_S7 = 1'b1;
    tick;
    chk("vma_release", bus.VMA_n, 1);
    bus.CYC_S7 = 1'b0;
    while (n % 10 != 3) tick;
    bus.CYC_S3 = 1'b1;
    bus.M68K_VPA_n = 1'b0;
    repeat (3) tick;
    bus.BUS_OWNED = 1'b0;
    tick;
    chk("drop_vma_oe", bus.VMA_OE, 0);
    chk("drop_vma_n", bus.VMA_n, 1);
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("drop_no_done", bus.VPA_DONE, 0);
      chk("drop_no_vma", bus.VMA_n, 1);
    end
    bus.CYC_S3 = 1'b0;
    bus.M68K_VPA_n = 1'b1;
    bus.BUS_OWNED = 1'b1;
    repeat (3) tick;
    while (n % 10 != 0) tick;
    bus.CYC_S3 = 1'b1;
    bus.M68K_VPA_n = 1'b0;
    repeat (12) tick;
    chk("p2_no_early", bus.VMA_n, 1);
    tick;
    chk("p2_next_period", bus.VMA_n, 0);
    rst_n = 1'b0;
    tick;
    chk("mid_e_out", bus.E_OUT, 0);
    chk("mid_e_oe", bus.E_OE, 0);
    chk("mid_vma_n", bus.VMA_n, 1);
    chk("mid_vma_oe", bus.VMA_OE, 0);
    chk("mid_vpa_done", bus.VPA_DONE, 0);
    chk("mid_phase", bus.E_PHASE, 0);
    bus.CYC_S3 = 1'b0;
    bus.M68K_VPA_n = 1'b1;
    rst_n = 1'b1;
    n = 0;
    tick;
`ifdef M68K_E_DETECT_EN
    chk("mid_e_oe_restart", bus.E_OE, 0);
`else
    chk("mid_e_oe_restart", bus.E_OE, 1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
